// File: rtl/vdc_ramsched_if.sv
// vdc_ramsched_if: display-fetch channels, CPU command port and RAM bus of
// the VDC 856x RAM slot scheduler bundled into one interface.
//
// Handshake: a CPU command transfers on a cycle where cpu_cmd_valid and
// cpu_cmd_ready are both high; cpu_cmd_ready is simply !cpu_busy, and a
// valid seen while not ready is dropped rather than held pending.
interface vdc_ramsched_if #(
    parameter int ADDR_BITS = 16,
    parameter int CHANNELS  = 4,
    parameter int WC_BITS   = 8
);
    logic                          slot_start;
    logic                          slot_end;
    logic [CHANNELS-1:0]           ch_req;
    logic [CHANNELS*ADDR_BITS-1:0] ch_addr;
    logic [CHANNELS-1:0]           ch_ack;
    logic [7:0]                    ch_data;
    logic                          cpu_cmd_valid;
    logic                          cpu_cmd_ready;
    logic [1:0]                    cpu_cmd;
    logic [15:0]                   cpu_ua_in;
    logic [15:0]                   cpu_ba_in;
    logic                          cpu_ua_ld;
    logic                          cpu_ba_ld;
    logic [WC_BITS-1:0]            cpu_wc;
    logic [7:0]                    cpu_wdata;
    logic                          cpu_dir;
    logic                          cpu_busy;
    logic [15:0]                   cpu_ua;
    logic [15:0]                   cpu_ba;
    logic [7:0]                    cpu_da;
    logic                          ram_rd;
    logic                          ram_we;
    logic [ADDR_BITS-1:0]          ram_addr;
    logic [7:0]                    ram_di;
    logic [7:0]                    ram_do;
    logic [2:0]                    dbg_cpu_state;
    logic [1:0]                    dbg_slot_kind;

    modport slave (
        input  slot_start, slot_end, ch_req, ch_addr,
        input  cpu_cmd_valid, cpu_cmd, cpu_ua_in, cpu_ba_in, cpu_ua_ld, cpu_ba_ld,
        input  cpu_wc, cpu_wdata, cpu_dir, ram_do,
        output ch_ack, ch_data, cpu_cmd_ready, cpu_busy, cpu_ua, cpu_ba, cpu_da,
        output ram_rd, ram_we, ram_addr, ram_di, dbg_cpu_state, dbg_slot_kind
    );

    modport master (
        output slot_start, slot_end, ch_req, ch_addr,
        output cpu_cmd_valid, cpu_cmd, cpu_ua_in, cpu_ba_in, cpu_ua_ld, cpu_ba_ld,
        output cpu_wc, cpu_wdata, cpu_dir, ram_do,
        input  ch_ack, ch_data, cpu_cmd_ready, cpu_busy, cpu_ua, cpu_ba, cpu_da,
        input  ram_rd, ram_we, ram_addr, ram_di, dbg_cpu_state, dbg_slot_kind
    );
endinterface

// File: rtl/vdc_ramsched.sv
// vdc_ramsched: single-port video RAM slot scheduler shared by CHANNELS
// display-fetch requesters and a CPU READ/WRITE/FILL/COPY block engine.
// Optional feature macro: VDC_RAMSCHED_DIR_EN (cpu_dir selects a descending
// step for the accepted command; without it the step is always +1).
module vdc_ramsched #(
    parameter int ADDR_BITS    = 16,
    parameter int CHANNELS     = 4,
    parameter int WC_BITS      = 8,
    parameter int STARVE_LIMIT = 15
) (
    input  logic           clk,
    input  logic           reset,
    vdc_ramsched_if.slave  bus
);
    localparam int CH_BITS = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int SW      = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    typedef enum logic [2:0] {C_IDLE, C_READ, C_WRITE, C_FILL, C_CRD, C_CWR} cpu_state_t;
    typedef enum logic [1:0] {K_NONE, K_IDLE, K_CH, K_CPU} slot_kind_t;

    cpu_state_t           cpu_state, state_nx, cmd_state;
    slot_kind_t           slot_kind, grant_kind;
    logic [CH_BITS-1:0]   slot_ch, ch_sel;
    logic                 ch_any;
    logic [15:0]          ua, ba, ua_nx, ba_nx, step;
    logic [WC_BITS-1:0]   wc_left, wc_nx;
    logic [7:0]           wdata_q, copy_buf, buf_nx, da, da_nx;
    logic [SW-1:0]        starve, starve_nx;
    logic                 close, cpu_close, busy_nx, force_cpu, accept, idle;
    logic                 g_rd, g_we;
    logic [ADDR_BITS-1:0] g_addr;
    logic [7:0]           g_di;
`ifdef VDC_RAMSCHED_DIR_EN
    logic                 dir_q;
`endif

    assign idle      = (cpu_state == C_IDLE);
    assign accept    = bus.cpu_cmd_valid && idle;
    assign close     = bus.slot_end && (slot_kind != K_NONE);
    assign cpu_close = close && (slot_kind == K_CPU);

`ifdef VDC_RAMSCHED_DIR_EN
    assign step = dir_q ? 16'hFFFF : 16'h0001;
`else
    assign step = 16'h0001;
`endif

    // Command decode: COPY starts with its source read.
    always_comb begin
        cmd_state = C_READ;
        case (bus.cpu_cmd)
            2'd0: cmd_state = C_READ;
            2'd1: cmd_state = C_WRITE;
            2'd2: cmd_state = C_FILL;
            2'd3: cmd_state = C_CRD;
            default: cmd_state = C_READ;
        endcase
    end

    // Next CPU engine state after closing the current slot; the grant below
    // sees this post-close view so a back-to-back start/end behaves as one.
    always_comb begin
        state_nx = cpu_state;
        ua_nx    = ua;
        ba_nx    = ba;
        wc_nx    = wc_left;
        buf_nx   = copy_buf;
        da_nx    = da;
        if (cpu_close) begin
            case (cpu_state)
                C_READ: begin
                    da_nx    = bus.ram_do;
                    state_nx = C_IDLE;
                end
                C_WRITE: begin
                    ua_nx    = ua + step;
                    state_nx = C_READ;
                end
                C_FILL: begin
                    ua_nx = ua + step;
                    wc_nx = wc_left - 1'b1;
                    if (wc_left == WC_BITS'(1)) state_nx = C_IDLE;
                end
                C_CRD: begin
                    buf_nx   = bus.ram_do;
                    ba_nx    = ba + step;
                    state_nx = C_CWR;
                end
                C_CWR: begin
                    ua_nx    = ua + step;
                    wc_nx    = wc_left - 1'b1;
                    state_nx = (wc_left == WC_BITS'(1)) ? C_IDLE : C_CRD;
                end
                default: state_nx = cpu_state;
            endcase
        end
    end

    // Slot grant: starved CPU, then lowest channel, then CPU, else idle read.
    always_comb begin
        busy_nx   = (state_nx != C_IDLE);
        force_cpu = (STARVE_LIMIT != 0) && busy_nx && (starve == SW'(STARVE_LIMIT));
        ch_any    = 1'b0;
        ch_sel    = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (bus.ch_req[i]) begin
                ch_any = 1'b1;
                ch_sel = CH_BITS'(i);
            end
        end
        if (force_cpu)    grant_kind = K_CPU;
        else if (ch_any)  grant_kind = K_CH;
        else if (busy_nx) grant_kind = K_CPU;
        else              grant_kind = K_IDLE;

        g_rd   = 1'b1;
        g_we   = 1'b0;
        g_addr = '1;
        g_di   = bus.ram_di;
        if (grant_kind == K_CH) begin
            g_addr = bus.ch_addr[ch_sel*ADDR_BITS +: ADDR_BITS];
        end else if (grant_kind == K_CPU) begin
            case (state_nx)
                C_READ:  g_addr = ADDR_BITS'(ua_nx);
                C_CRD:   g_addr = ADDR_BITS'(ba_nx);
                C_CWR: begin
                    g_rd = 1'b0; g_we = 1'b1; g_addr = ADDR_BITS'(ua_nx); g_di = buf_nx;
                end
                default: begin
                    g_rd = 1'b0; g_we = 1'b1; g_addr = ADDR_BITS'(ua_nx); g_di = wdata_q;
                end
            endcase
        end

        starve_nx = starve;
        if (bus.slot_start) begin
            if (grant_kind == K_CPU || !busy_nx)    starve_nx = '0;
            else if (starve != SW'(STARVE_LIMIT))   starve_nx = starve + 1'b1;
        end else if (!busy_nx) begin
            starve_nx = '0;
        end
    end

    // Engine, slot bookkeeping and RAM strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_state   <= C_IDLE;
            slot_kind   <= K_NONE;
            slot_ch     <= '0;
            ua          <= '0;
            ba          <= '0;
            wc_left     <= '0;
            wdata_q     <= '0;
            copy_buf    <= '0;
            da          <= '0;
            starve      <= '0;
            bus.ram_rd   <= 1'b0;
            bus.ram_we   <= 1'b0;
            bus.ram_addr <= '1;
            bus.ram_di   <= '0;
            bus.ch_ack   <= '0;
            bus.ch_data  <= '0;
`ifdef VDC_RAMSCHED_DIR_EN
            dir_q       <= 1'b0;
`endif
        end else begin
            cpu_state <= accept ? cmd_state : state_nx;
            wc_left   <= accept ? bus.cpu_wc : wc_nx;
            ua        <= (idle && bus.cpu_ua_ld) ? bus.cpu_ua_in : ua_nx;
            ba        <= (idle && bus.cpu_ba_ld) ? bus.cpu_ba_in : ba_nx;
            copy_buf  <= buf_nx;
            da        <= da_nx;
            starve    <= starve_nx;
            if (accept) wdata_q <= bus.cpu_wdata;
`ifdef VDC_RAMSCHED_DIR_EN
            if (accept) dir_q <= bus.cpu_dir;
`endif
            if (bus.slot_start) begin
                slot_kind <= grant_kind;
                if (grant_kind == K_CH) slot_ch <= ch_sel;
            end else if (close) begin
                slot_kind <= K_NONE;
            end
            bus.ram_rd <= bus.slot_start && g_rd;
            bus.ram_we <= bus.slot_start && g_we;
            if (bus.slot_start) begin
                bus.ram_addr <= g_addr;
                bus.ram_di   <= g_di;
            end
            bus.ch_ack <= '0;
            if (close && slot_kind == K_CH) begin
                bus.ch_ack[slot_ch] <= 1'b1;
                bus.ch_data         <= bus.ram_do;
            end
        end
    end

    assign bus.cpu_busy      = !idle;
    assign bus.cpu_cmd_ready = idle;
    assign bus.cpu_ua        = ua;
    assign bus.cpu_ba        = ba;
    assign bus.cpu_da        = da;
    assign bus.dbg_cpu_state = cpu_state;
    assign bus.dbg_slot_kind = slot_kind;
endmodule

// File: tb/tb_vdc_ramsched.sv
// tb_vdc_ramsched: randomized and directed stimulus for vdc_ramsched, checked
// every cycle against a slot-level model that expands each CPU command into
// its full list of RAM accesses at acceptance time.
`timescale 1ns/1ps
module tb_vdc_ramsched;
    localparam int AB = 16;
    localparam int CH = 4;
    localparam int WB = 8;
    localparam int SL = 3;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic        use_src;
        logic [15:0] src;
        logic [7:0]  wd;
        logic        to_da;
        logic [15:0] ua_after;
        logic [15:0] ba_after;
    } op_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vdc_ramsched_if #(.ADDR_BITS(AB), .CHANNELS(CH), .WC_BITS(WB)) bus ();
    vdc_ramsched #(.ADDR_BITS(AB), .CHANNELS(CH), .WC_BITS(WB), .STARVE_LIMIT(SL))
        dut (.clk(clk), .reset(reset), .bus(bus));

    // ---------------- RAM device ----------------
    logic [7:0] mem     [0:65535];
    logic [7:0] ref_mem [0:65535];
    assign bus.ram_do = mem[bus.ram_addr];
    always @(posedge clk) if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_di;

    // ---------------- scoreboard ----------------
    int n_chk = 0;
    int n_pass = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    op_t         opq[$];
    op_t         op;
    logic [15:0] m_ua, m_ba, m_addr;
    logic [7:0]  m_da;
    int          m_starve, m_kind, m_ch;
    logic        exp_rd, exp_we, exp_busy, chk_en = 1'b0;
    logic [15:0] exp_addr, exp_ua, exp_ba;
    logic [7:0]  exp_di, exp_chd, exp_da;
    logic [3:0]  exp_ack;

    task automatic expand_cmd(input logic [1:0] cmd, input int wc, input logic [7:0] wd, input int stp);
        op_t o;
        int  n;
        n = (wc == 0) ? (1 << WB) : wc;
        o.use_src = 1'b0; o.src = '0; o.wd = wd; o.to_da = 1'b0; o.ba_after = m_ba;
        case (cmd)
            2'd0: begin
                o.we = 0; o.addr = m_ua; o.to_da = 1; o.ua_after = m_ua; opq.push_back(o);
            end
            2'd1: begin
                o.we = 0; o.addr = m_ua; o.ua_after = 16'(int'(m_ua) + stp);
                o.we = 1; opq.push_back(o);
                o.we = 0; o.addr = o.ua_after; o.to_da = 1; opq.push_back(o);
            end
            2'd2: for (int k = 0; k < n; k++) begin
                o.we = 1; o.addr = 16'(int'(m_ua) + k*stp);
                o.ua_after = 16'(int'(m_ua) + (k+1)*stp); opq.push_back(o);
            end
            default: for (int k = 0; k < n; k++) begin
                o.we = 0; o.use_src = 0; o.addr = 16'(int'(m_ba) + k*stp);
                o.ua_after = 16'(int'(m_ua) + k*stp);
                o.ba_after = 16'(int'(m_ba) + (k+1)*stp); opq.push_back(o);
                o.we = 1; o.use_src = 1; o.src = o.addr; o.addr = 16'(int'(m_ua) + k*stp);
                o.ua_after = 16'(int'(m_ua) + (k+1)*stp); opq.push_back(o);
            end
        endcase
    endtask

    always @(posedge clk) begin
        bit pre_idle, busy;
        int first, stp;
        exp_rd = 0; exp_we = 0; exp_ack = '0;
        if (reset) begin
            opq.delete();
            m_ua = 0; m_ba = 0; m_da = 0; m_starve = 0; m_kind = 0; m_ch = 0; m_addr = 0;
            exp_addr = 16'hFFFF; exp_di = 0; exp_chd = 0; chk_en = 1;
        end else begin
            pre_idle = (opq.size() == 0);
            if (bus.slot_end && m_kind != 0) begin
                if (m_kind == 2) begin
                    exp_ack[m_ch] = 1'b1;
                    exp_chd = ref_mem[m_addr];
                end else if (m_kind == 3) begin
                    op = opq.pop_front();
                    if (op.to_da) m_da = ref_mem[op.addr];
                    m_ua = op.ua_after;
                    m_ba = op.ba_after;
                end
                m_kind = 0;
            end
            busy = (opq.size() != 0);
            if (bus.slot_start) begin
                first = -1;
                for (int i = CH - 1; i >= 0; i--) if (bus.ch_req[i]) first = i;
                if (busy && SL != 0 && m_starve == SL) m_kind = 3;
                else if (first >= 0)                   m_kind = 2;
                else if (busy)                         m_kind = 3;
                else                                   m_kind = 1;
                if (m_kind == 3 || !busy) m_starve = 0;
                else if (m_starve < SL)   m_starve++;
                if (m_kind == 2) begin
                    m_ch = first; exp_rd = 1; exp_addr = bus.ch_addr[first*AB +: AB];
                end else if (m_kind == 3) begin
                    op = opq[0];
                    exp_addr = op.addr;
                    if (op.we) begin
                        exp_we = 1;
                        exp_di = op.use_src ? ref_mem[op.src] : op.wd;
                        ref_mem[op.addr] = exp_di;
                    end else exp_rd = 1;
                end else begin
                    exp_rd = 1; exp_addr = 16'hFFFF;
                end
                m_addr = exp_addr;
            end else if (!busy) m_starve = 0;
            if (pre_idle) begin
                if (bus.cpu_ua_ld) m_ua = bus.cpu_ua_in;
                if (bus.cpu_ba_ld) m_ba = bus.cpu_ba_in;
                if (bus.cpu_cmd_valid) begin
`ifdef VDC_RAMSCHED_DIR_EN
                    stp = bus.cpu_dir ? -1 : 1;
`else
                    stp = 1;
`endif
                    expand_cmd(bus.cpu_cmd, int'(bus.cpu_wc), bus.cpu_wdata, stp);
                end
            end
        end
        exp_busy = (opq.size() != 0);
        exp_ua = m_ua; exp_ba = m_ba; exp_da = m_da;
    end

    // Per-cycle compare, away from the active edge.
    int ack0_cnt = 0, ack2_cnt = 0;
    always @(negedge clk) begin
        if (chk_en) begin
            chk("ram_rd", bus.ram_rd, exp_rd);
            chk("ram_we", bus.ram_we, exp_we);
            chk("ram_addr", bus.ram_addr, exp_addr);
            if (exp_we) chk("ram_di", bus.ram_di, exp_di);
            chk("ch_ack", bus.ch_ack, exp_ack);
            chk("ch_data", bus.ch_data, exp_chd);
            chk("cpu_busy", bus.cpu_busy, exp_busy);
            chk("cpu_cmd_ready", bus.cpu_cmd_ready, !exp_busy);
            chk("cpu_ua", bus.cpu_ua, exp_ua);
            chk("cpu_ba", bus.cpu_ba, exp_ba);
            chk("cpu_da", bus.cpu_da, exp_da);
        end
        if (bus.ch_ack[0]) ack0_cnt++;
        if (bus.ch_ack[2]) ack2_cnt++;
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic poke(input logic [15:0] a, input logic [7:0] v);
        mem[a] <= v; ref_mem[a] = v;
    endtask

    task automatic do_slot(input int len);
        bus.slot_start = 1; cyc(); bus.slot_start = 0;
        repeat (len - 1) cyc();
        bus.slot_end = 1; cyc(); bus.slot_end = 0;
    endtask

    task automatic load(input logic [15:0] ua, input logic [15:0] ba);
        bus.cpu_ua_in = ua; bus.cpu_ba_in = ba; bus.cpu_ua_ld = 1; bus.cpu_ba_ld = 1;
        cyc(); bus.cpu_ua_ld = 0; bus.cpu_ba_ld = 0;
    endtask

    task automatic issue(input logic [1:0] cmd, input int wc, input logic [7:0] wd, input logic dir);
        bus.cpu_cmd = cmd; bus.cpu_wc = WB'(wc); bus.cpu_wdata = wd; bus.cpu_dir = dir;
        bus.cpu_cmd_valid = 1; cyc(); bus.cpu_cmd_valid = 0;
    endtask

    task automatic run_until_idle(input int budget, output int slots);
        slots = 0;
        while (bus.cpu_busy && slots < budget) begin
            do_slot(1 + (slots % 2));
            slots++;
        end
        chk("idle_within_budget", bus.cpu_busy, 1'b0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int slots;
        logic [7:0] src_v [0:2];
        bit all_eq;
        reset = 1;
        bus.slot_start = 0; bus.slot_end = 0; bus.ch_req = '0; bus.ch_addr = '0;
        bus.cpu_cmd_valid = 0; bus.cpu_cmd = 0; bus.cpu_ua_in = 0; bus.cpu_ba_in = 0;
        bus.cpu_ua_ld = 0; bus.cpu_ba_ld = 0; bus.cpu_wc = 0; bus.cpu_wdata = 0; bus.cpu_dir = 0;
        for (int i = 0; i < 65536; i++) begin
            logic [7:0] v;
            v = 8'($urandom);
            mem[i] <= v; ref_mem[i] = v;
        end
        repeat (3) cyc();
        chk("reset_ram_addr", bus.ram_addr, 16'hFFFF);
        chk("reset_ram_di", bus.ram_di, 8'h00);
        chk("reset_cpu_busy", bus.cpu_busy, 1'b0);
        reset = 0;
        cyc();

        // Channel priority: channel 0 beats channel 2 every slot.
        bus.ch_addr = {16'h0C00, 16'h0A00, 16'h0B00, 16'h0900};
        bus.ch_req = 4'b0101;
        ack0_cnt = 0; ack2_cnt = 0;
        repeat (3) do_slot(2);
        cyc();
        chk("prio_ack0_count", ack0_cnt, 3);
        chk("prio_ack2_count", ack2_cnt, 0);
        bus.ch_req = '0;

        // READ
        poke(16'h1234, 8'h5A);
        load(16'h1234, 16'h0000);
        issue(2'd0, 1, 8'h00, 0);
        do_slot(1);
        chk("read_da", bus.cpu_da, 8'h5A);
        chk("read_busy_done", bus.cpu_busy, 1'b0);

        // WRITE then readback of the next address
        poke(16'h0100, 8'h3C);
        load(16'h00FF, 16'h0000);
        issue(2'd1, 1, 8'h77, 0);
        run_until_idle(10, slots);
        chk("write_slots", slots, 2);
        chk("write_ua", bus.cpu_ua, 16'h0100);
        chk("write_da", bus.cpu_da, 8'h3C);
        chk("write_mem", mem[16'h00FF], 8'h77);

        // COPY of three words
        for (int i = 0; i < 3; i++) begin
            src_v[i] = 8'($urandom);
            poke(16'h2000 + 16'(i), src_v[i]);
        end
        load(16'h3000, 16'h2000);
        issue(2'd3, 3, 8'h00, 0);
        run_until_idle(20, slots);
        chk("copy_slots", slots, 6);
        chk("copy_ba", bus.cpu_ba, 16'h2003);
        chk("copy_ua", bus.cpu_ua, 16'h3003);
        for (int i = 0; i < 3; i++) chk("copy_mem", mem[16'h3000 + 16'(i)], src_v[i]);

        // COPY with wc=0 moves 256 words
        load(16'h5000, 16'h4000);
        issue(2'd3, 0, 8'h00, 0);
        run_until_idle(600, slots);
        chk("copy256_slots", slots, 512);
        chk("copy256_ua", bus.cpu_ua, 16'h5100);
        chk("copy256_ba", bus.cpu_ba, 16'h4100);
        all_eq = 1;
        for (int i = 0; i < 256; i++)
            if (mem[16'h5000 + 16'(i)] !== mem[16'h4000 + 16'(i)]) all_eq = 0;
        chk("copy256_data", all_eq, 1'b1);

        // Starvation guard: CPU forced every (SL+1)th slot
        bus.ch_req = 4'b0001;
        load(16'h0400, 16'h0000);
        issue(2'd2, 2, 8'hAB, 0);
        run_until_idle(20, slots);
        chk("starve_slots", slots, 8);
        chk("starve_mem", mem[16'h0401], 8'hAB);
        bus.ch_req = '0;

        // Direction
        load(16'h0001, 16'h0000);
        issue(2'd2, 3, 8'hC5, 1);
        run_until_idle(20, slots);
`ifdef VDC_RAMSCHED_DIR_EN
        chk("dir_ua", bus.cpu_ua, 16'hFFFE);
        chk("dir_mem_last", mem[16'hFFFF], 8'hC5);
`else
        chk("dir_ua", bus.cpu_ua, 16'h0004);
        chk("dir_mem_last", mem[16'h0003], 8'hC5);
`endif

        // Reset mid-block aborts, stray slot_end afterwards is ignored
        load(16'h0600, 16'h0000);
        issue(2'd2, 5, 8'h11, 0);
        do_slot(1); do_slot(1);
        bus.slot_start = 1; cyc(); bus.slot_start = 0;
        reset = 1; cyc(); cyc(); reset = 0;
        bus.slot_end = 1; cyc(); bus.slot_end = 0;
        cyc();
        chk("abort_busy", bus.cpu_busy, 1'b0);
        chk("abort_ua", bus.cpu_ua, 16'h0000);

        // Randomized phase
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 39) == 0) begin
                bus.ch_req = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
                bus.ch_addr = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
            end
            bus.slot_start = ($urandom_range(0, 2) == 0);
            bus.slot_end = ($urandom_range(0, 2) == 0);
            bus.cpu_ua_ld = ($urandom_range(0, 15) == 0);
            bus.cpu_ba_ld = ($urandom_range(0, 15) == 0);
            bus.cpu_ua_in = 16'($urandom);
            bus.cpu_ba_in = 16'($urandom);
            bus.cpu_cmd_valid = ($urandom_range(0, 7) == 0);
            bus.cpu_cmd = 2'($urandom);
            bus.cpu_wc = WB'($urandom_range(1, 5));
            bus.cpu_wdata = 8'($urandom);
            bus.cpu_dir = 1'($urandom);
            cyc();
        end
        bus.slot_start = 0; bus.slot_end = 0; bus.cpu_cmd_valid = 0;
        bus.cpu_ua_ld = 0; bus.cpu_ba_ld = 0; bus.ch_req = '0;
        repeat (3) cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
